mem_stage_cached: RTL and testbench

- Parametrised MEM pipeline stage: direct-mapped, write-through, no-write-allocate data cache in front of a handshaked backing memory.
- Stalls the pipeline on misses and writes.
- Keeps the sprite/ALU result mux and branch-condition resolution.
- Halt port reuses the cache read path for debug readout.

---
 rtl/mem_stage_cached_pkg.sv | 25 ++
 rtl/dm_cache_array.sv | 49 ++++
 rtl/mem_stage_cached.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage_cached.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_cached_pkg.sv
// Shared types for the cached MEM stage: branch codes, FSM states, default widths.
package mem_stage_cached_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 22;
  localparam int DEF_IDX_W  = 3;

  typedef enum logic [2:0] {
    BR_NEQ    = 3'd0,
    BR_EQ     = 3'd1,
    BR_GT     = 3'd2,
    BR_LT     = 3'd3,
    BR_GTE    = 3'd4,
    BR_LTE    = 3'd5,
    BR_OVFL   = 3'd6,
    BR_UNCOND = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/dm_cache_array.sv
// Direct-mapped one-word-line storage: combinational lookup, single synchronous write port.
// Only valid bits are reset; tag/data contents survive reset and are masked by valid.
module dm_cache_array
  import mem_stage_cached_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        lk_idx,
  input  logic [ADDR_W-IDX_W-1:0] lk_tag,
  output logic                    lk_hit,
  output logic [DATA_W-1:0]       lk_data,
  input  logic                    wr_en,
  input  logic                    wr_fill,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [ADDR_W-IDX_W-1:0] wr_tag,
  input  logic [DATA_W-1:0]       wr_data
);

  localparam int NLINES = 1 << IDX_W;
  localparam int TAG_W  = ADDR_W - IDX_W;

  logic [NLINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [DATA_W-1:0] data_q [NLINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en && wr_fill) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Store-hits update data only; tag is rewritten only by a line fill.
  always_ff @(posedge clk) begin
    if (wr_en)            data_q[wr_idx] <= wr_data;
    if (wr_en && wr_fill) tag_q[wr_idx]  <= wr_tag;
  end

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_data = data_q[lk_idx];

endmodule

// File: rtl/mem_stage_cached.sv
// MEM stage with direct-mapped write-through cache, sprite/ALU mux and branch resolution.
// Define MEM_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module mem_stage_cached
  import mem_stage_cached_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hlt,
  input  logic [ADDR_W-1:0] hlt_addr,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] sprite_data,
  input  logic              sprite_ALU_select,
  input  logic              flag_ov,
  input  logic              flag_neg,
  input  logic              flag_zero,
  input  logic [2:0]        branch_condition,
  output logic              stall,
  output logic [DATA_W-1:0] mem_result,
  output logic              cache_hit,
  output logic [DATA_W-1:0] sprite_ALU_result,
  output logic              branch_taken,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - IDX_W;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_result_q, mem_result_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_W-1:0] lk_addr;
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              eff_rd, eff_wr;
  logic              arr_hit;
  logic [DATA_W-1:0] arr_data;
  logic              arr_wr_en, arr_wr_fill;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic [TAG_W-1:0]  arr_wr_tag;
  logic [DATA_W-1:0] arr_wr_data;
  logic              stall_raw;
  logic              hit_ev, miss_ev;

  // Halt overrides the pipeline op with a debug read; store beats load when both are set.
  assign lk_addr = hlt ? hlt_addr : addr;
  assign lk_idx  = lk_addr[IDX_W-1:0];
  assign lk_tag  = lk_addr[ADDR_W-1:IDX_W];
  assign eff_wr  = !hlt && we;
  assign eff_rd  = hlt || re;

  dm_cache_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .lk_idx  (lk_idx),
    .lk_tag  (lk_tag),
    .lk_hit  (arr_hit),
    .lk_data (arr_data),
    .wr_en   (arr_wr_en && !rst),
    .wr_fill (arr_wr_fill),
    .wr_idx  (arr_wr_idx),
    .wr_tag  (arr_wr_tag),
    .wr_data (arr_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    mem_result_d = mem_result_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    stall_raw    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_wr_fill  = 1'b0;
    arr_wr_idx   = lk_idx;
    arr_wr_tag   = lk_tag;
    arr_wr_data  = wr_data;
    hit_ev       = 1'b0;
    miss_ev      = 1'b0;

    case (state_q)
      IDLE: begin
        if (eff_wr) begin
          stall_raw   = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = wr_data;
          arr_wr_en   = arr_hit;
          state_d     = WRITE;
        end else if (eff_rd) begin
          if (arr_hit) begin
            mem_result_d = arr_data;
            hit_ev       = 1'b1;
          end else begin
            stall_raw  = 1'b1;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = lk_addr;
            miss_ev    = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        stall_raw = !mem_ack;
        if (mem_ack) begin
          // Index/tag come from the registered request so the fill is self-contained.
          arr_wr_en    = 1'b1;
          arr_wr_fill  = 1'b1;
          arr_wr_idx   = mem_addr_q[IDX_W-1:0];
          arr_wr_tag   = mem_addr_q[ADDR_W-1:IDX_W];
          arr_wr_data  = mem_rdata;
          mem_result_d = mem_rdata;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        stall_raw = !mem_ack;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_result_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_result_q <= mem_result_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign stall      = stall_raw && !rst;
  assign cache_hit  = (state_q == IDLE) && arr_hit;
  assign mem_result = mem_result_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_ev && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_ev && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign sprite_ALU_result = sprite_ALU_select ? sprite_data : ALU_result;

  always_comb begin
    branch_taken = 1'b0;
    case (br_cond_e'(branch_condition))
      BR_NEQ:    branch_taken = !flag_zero;
      BR_EQ:     branch_taken = flag_zero;
      BR_GT:     branch_taken = !flag_zero && !flag_neg;
      BR_LT:     branch_taken = flag_neg;
      BR_GTE:    branch_taken = !flag_neg;
      BR_LTE:    branch_taken = flag_neg || flag_zero;
      BR_OVFL:   branch_taken = flag_ov;
      BR_UNCOND: branch_taken = 1'b1;
      default:   branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_cached.sv
// Bench for mem_stage_cached: cache scoreboard sequences plus a branch/mux vector table.
module tb_mem_stage_cached;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we, hlt;
  logic [21:0] addr, hlt_addr;
  logic [31:0] wr_data, ALU_result, sprite_data;
  logic        sprite_ALU_select, flag_ov, flag_neg, flag_zero;
  logic [2:0]  branch_condition;
  logic        stall, cache_hit, branch_taken;
  logic [31:0] mem_result, sprite_ALU_result;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  mem_stage_cached dut (
    .clk               (clk),
    .rst               (rst),
    .re                (re),
    .we                (we),
    .addr              (addr),
    .wr_data           (wr_data),
    .hlt               (hlt),
    .hlt_addr          (hlt_addr),
    .ALU_result        (ALU_result),
    .sprite_data       (sprite_data),
    .sprite_ALU_select (sprite_ALU_select),
    .flag_ov           (flag_ov),
    .flag_neg          (flag_neg),
    .flag_zero         (flag_zero),
    .branch_condition  (branch_condition),
    .stall             (stall),
    .mem_result        (mem_result),
    .cache_hit         (cache_hit),
    .sprite_ALU_result (sprite_ALU_result),
    .branch_taken      (branch_taken),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
`ifdef MEM_PERF_CNT_EN
    ,
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mem_model [logic [21:0]];

  typedef struct {
    logic [2:0]  cond;
    logic        z, n, v, sel;
    logic [31:0] alu, spr;
    logic        exp_taken;
    logic [31:0] exp_res;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    re = 1'b0;
    we = 1'b0;
    hlt = 1'b0;
  endtask

  task automatic do_read(input logic [21:0] a, input bit use_hlt, input bit exp_hit, input int ack_dly);
    logic [31:0] exp;
    @(negedge clk);
    if (use_hlt) begin
      // Store request and a different pipeline address must be ignored under halt.
      hlt = 1'b1; hlt_addr = a; addr = 22'h3F; re = 1'b0; we = 1'b1; wr_data = 32'h5555_AAAA;
    end else begin
      hlt = 1'b0; addr = a; re = 1'b1; we = 1'b0;
    end
    #1;
    check("rd_cache_hit", cache_hit, exp_hit);
    check("rd_stall", stall, !exp_hit);
    sb_q.push_back(mem_model[a]);
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    if (!exp_hit) begin
      @(posedge clk); #1;
      check("fill_req", mem_req, 1'b1);
      check("fill_we", mem_we, 1'b0);
      check("fill_addr", mem_addr, a);
      for (int i = 1; i < ack_dly; i++) begin
        @(negedge clk); #1;
        check("fill_wait_stall", stall, 1'b1);
      end
      @(negedge clk);
      mem_rdata = mem_model[a];
      mem_ack = 1'b1;
      #1;
      check("fill_ack_stall", stall, 1'b0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    idle_inputs();
    exp = sb_q.pop_front();
    check("rd_result", mem_result, exp);
    check("rd_req_low", mem_req, 1'b0);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [31:0] d, input bit exp_hit, input int ack_dly);
    logic [31:0] prev;
    @(negedge clk);
    hlt = 1'b0; addr = a; wr_data = d; we = 1'b1; re = 1'($urandom_range(0, 1));
    #1;
    prev = mem_result;
    check("wr_cache_hit", cache_hit, exp_hit);
    check("wr_stall", stall, 1'b1);
    @(posedge clk); #1;
    check("wr_req", mem_req, 1'b1);
    check("wr_we", mem_we, 1'b1);
    check("wr_addr", mem_addr, a);
    check("wr_wdata", mem_wdata, d);
    for (int i = 1; i < ack_dly; i++) begin
      @(negedge clk); #1;
      check("wr_wait_stall", stall, 1'b1);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("wr_ack_stall", stall, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    idle_inputs();
    check("wr_req_low", mem_req, 1'b0);
    check("wr_result_hold", mem_result, prev);
    mem_model[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic [7:0]  sweep;
    rst = 1'b1;
    idle_inputs();
    addr = '0; hlt_addr = '0; wr_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    ALU_result = '0; sprite_data = '0; sprite_ALU_select = 1'b0;
    flag_ov = 1'b0; flag_neg = 1'b0; flag_zero = 1'b0; branch_condition = '0;
    mem_model[22'h00005] = 32'hDEAD_BEEF;
    mem_model[22'h0000D] = 32'h0BAD_C0DE;
    mem_model[22'h00003] = 32'h7777_0003;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 22'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_result", mem_result, 32'h0);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_cache_hit", cache_hit, 1'b0);
    check("idle_stall", stall, 1'b0);

    do_read(22'h00005, 1'b0, 1'b0, 3);
    do_read(22'h00005, 1'b0, 1'b1, 0);
    do_write(22'h00005, 32'h1234_5678, 1'b1, 2);
    do_read(22'h00005, 1'b0, 1'b1, 0);
    do_write(22'h0000D, 32'hCAFE_F00D, 1'b0, 1);
    do_read(22'h0000D, 1'b0, 1'b0, 1);
    do_read(22'h00005, 1'b0, 1'b0, 2);
    do_read(22'h0000D, 1'b0, 1'b0, 1);
    do_read(22'h00005, 1'b0, 1'b0, 1);
    do_read(22'h00005, 1'b1, 1'b1, 0);
    do_read(22'h00003, 1'b1, 1'b0, 2);
    do_read(22'h00003, 1'b0, 1'b1, 0);

    // Stray ack in IDLE must not start a transaction or touch the result.
    @(negedge clk);
    prev = mem_result;
    mem_rdata = 32'hFFFF_FFFF;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_req", mem_req, 1'b0);
    check("stray_ack_result", mem_result, prev);

`ifdef MEM_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

    // Reset in the middle of a fill abandons it.
    @(negedge clk);
    addr = 22'h0000D; re = 1'b1;
    @(posedge clk); #1;
    check("midfill_req", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midfill_rst_req", mem_req, 1'b0);
    check("midfill_rst_stall", stall, 1'b0);
    check("midfill_rst_result", mem_result, 32'h0);
    re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(22'h00005, 1'b0, 1'b0, 1);

    sweep = 8'b1011_0010;
    for (int c = 0; c < 8; c++) begin
      vecs[c].cond = 3'(c);
      vecs[c].z = 1'b1; vecs[c].n = 1'b0; vecs[c].v = 1'b0;
      vecs[c].sel = 1'(c % 2);
      vecs[c].alu = 32'h0000_1000 + 32'(c);
      vecs[c].spr = 32'h0000_A000 + 32'(c);
      vecs[c].exp_taken = sweep[c];
      vecs[c].exp_res = (c % 2 == 1) ? 32'h0000_A000 + 32'(c) : 32'h0000_1000 + 32'(c);
    end
    vecs[8]  = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111, 32'h2222, 1'b1, 32'h1111};
    vecs[9]  = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111, 32'h2222, 1'b1, 32'h2222};
    vecs[10] = '{3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3333, 32'h4444, 1'b0, 32'h3333};
    vecs[11] = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3333, 32'h4444, 1'b1, 32'h4444};
    vecs[12] = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5555, 32'h6666, 1'b0, 32'h5555};
    vecs[13] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5555, 32'h6666, 1'b0, 32'h6666};
    vecs[14] = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7777, 32'h8888, 1'b1, 32'h7777};
    vecs[15] = '{3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7777, 32'h8888, 1'b1, 32'h8888};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      branch_condition = vecs[i].cond;
      flag_zero = vecs[i].z; flag_neg = vecs[i].n; flag_ov = vecs[i].v;
      sprite_ALU_select = vecs[i].sel;
      ALU_result = vecs[i].alu; sprite_data = vecs[i].spr;
      #1;
      check($sformatf("branch_taken[%0d]", i), branch_taken, vecs[i].exp_taken);
      check($sformatf("sprite_alu[%0d]", i), sprite_ALU_result, vecs[i].exp_res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
